// File: rtl/dmem_mmio_pkg.sv
// dmem_mmio_pkg: shared definitions for the data-side responder.
//   - MMIO register offsets (word offset inside the MMIO window)
//   - STATUS register bit positions
//   - region decode enum used by the address decoder
package dmem_mmio_pkg;

    // MMIO register offsets, selected by daddr[1:0] inside the window.
    localparam logic [1:0] OUT_DATA_OFS = 2'd0;
    localparam logic [1:0] STATUS_OFS   = 2'd1;
    localparam logic [1:0] CYCLE_OFS    = 2'd2;
    localparam logic [1:0] RSVD_OFS     = 2'd3;

    // STATUS layout: bit0 empty, bit1 full, bit2 overflow, bits[15:8] count.
    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        REG_RAM,
        REG_MMIO,
        REG_UNMAPPED
    } region_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational head output.
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   enqueue request; dropped when full unless a pop happens too
//   pop           dequeue request; ignored when empty
//   rdata         head word, 0 while empty
//   full, empty   occupancy flags
//   count         number of stored words, 0..FIFO_DEPTH
module sync_fifo #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_W-1:0]             wdata,
    output logic [DATA_W-1:0]             rdata,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign pop_ok  = pop & ~empty;
    // When full, a same-cycle pop frees the slot the push lands in.
    assign push_ok = push & (~full | pop_ok);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: data-memory responder for the pipelined core.
// Decodes word address daddr into a data RAM (daddr[9]=0) and a 4-register
// MMIO window at 0x200..0x203 (OUT_DATA, STATUS, CYCLE, reserved). Reads are
// combinational; writes land on the rising edge.
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   d_w, d_r           write / read request from the core
//   daddr, ddata_w     word address, write data
//   ddata_r            read data (0 when idle or unmapped)
//   out_data/valid     result FIFO head and non-empty flag
//   out_ready          consumer accepts the head this cycle
//   err                sticky access error, only when DMEM_ERR_EN is defined
// Handshake: a word leaves the FIFO at the rising edge where out_valid and
// out_ready are both 1; out_valid never depends on out_ready.
// Build option: define DMEM_ERR_EN to add the err port and its error logic.
module dmem_mmio_responder
    import dmem_mmio_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int RAM_WORDS  = 512,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              d_w,
    input  logic              d_r,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] ddata_w,
    output logic [DATA_W-1:0] ddata_r,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef DMEM_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] ram [RAM_WORDS];
    logic [DATA_W-1:0] cycle_cnt;
    logic              overflow;
    region_e           region;
    logic [1:0]        mmio_ofs;
    logic [DATA_W-1:0] status_word;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    logic              mmio_wr;
    logic              ram_we;

    always_comb begin
        region = REG_RAM;
        if (daddr[ADDR_W-1]) begin
            region = (daddr[ADDR_W-2:2] == '0) ? REG_MMIO : REG_UNMAPPED;
        end
    end

    assign mmio_ofs  = daddr[1:0];
    assign mmio_wr   = d_w && (region == REG_MMIO);
    assign ram_we    = d_w && (region == REG_RAM);
    assign fifo_push = mmio_wr && (mmio_ofs == OUT_DATA_OFS);
    assign fifo_pop  = out_valid && out_ready;
    assign out_valid = ~fifo_empty;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (ddata_w),
        .rdata (out_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status_word                            = '0;
        status_word[STAT_EMPTY_BIT]            = fifo_empty;
        status_word[STAT_FULL_BIT]             = fifo_full;
        status_word[STAT_OVF_BIT]              = overflow;
        status_word[STAT_COUNT_LSB +: CNT_W]   = fifo_count;
    end

    // Read path samples the RAM array before this edge's write, so a
    // same-cycle read of a written address returns the old word.
    always_comb begin
        ddata_r = '0;
        if (d_r) begin
            case (region)
                REG_RAM:  ddata_r = ram[daddr[RAM_AW-1:0]];
                REG_MMIO: begin
                    case (mmio_ofs)
                        OUT_DATA_OFS: ddata_r = DATA_W'(fifo_count);
                        STATUS_OFS:   ddata_r = status_word;
                        CYCLE_OFS:    ddata_r = cycle_cnt;
                        default:      ddata_r = '0;
                    endcase
                end
                default:  ddata_r = '0;
            endcase
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge CLK) begin
        if (ram_we) ram[daddr[RAM_AW-1:0]] <= ddata_w;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cycle_cnt <= '0;
            overflow  <= 1'b0;
        end else begin
            if (mmio_wr && (mmio_ofs == CYCLE_OFS)) cycle_cnt <= ddata_w;
            else                                    cycle_cnt <= cycle_cnt + DATA_W'(1);

            // A push onto a full FIFO is only lost when nothing pops that edge.
            if (mmio_wr && (mmio_ofs == STATUS_OFS))       overflow <= 1'b0;
            else if (fifo_push && fifo_full && !fifo_pop)  overflow <= 1'b1;
        end
    end

`ifdef DMEM_ERR_EN
    logic err_cond;

    assign err_cond = (d_r && d_w)
                   || ((d_r || d_w) && (region == REG_UNMAPPED))
                   || (mmio_wr && (mmio_ofs == RSVD_OFS));

    always_ff @(posedge CLK) begin
        if (RST)           err <= 1'b0;
        else if (err_cond) err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: directed scenarios plus a randomized run,
// all checked against a behavioural model (RAM array, word queue for the
// FIFO, integer cycle counter) updated on every rising edge.
module tb_dmem_mmio_responder;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 32;
    localparam int RAM_WORDS  = 512;
    localparam int FIFO_DEPTH = 8;

    logic              CLK = 1'b0;
    logic              RST;
    logic              d_w;
    logic              d_r;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] ddata_w;
    logic [DATA_W-1:0] ddata_r;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
`ifdef DMEM_ERR_EN
    logic              err;
`endif

    int total = 0;
    int bad   = 0;

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    dmem_mmio_responder #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RAM_WORDS  (RAM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .d_w       (d_w),
        .d_r       (d_r),
        .daddr     (daddr),
        .ddata_w   (ddata_w),
        .ddata_r   (ddata_r),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DMEM_ERR_EN
        ,
        .err       (err)
`endif
    );

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] m_ram [RAM_WORDS];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] m_cycle;
    bit                m_ovf;

    always @(posedge CLK) begin : model
        int  n;
        bit  popped;
        n = exp_q.size();
        if (d_w && !daddr[9]) m_ram[daddr[8:0]] = ddata_w;
        if (RST) begin
            exp_q.delete();
            m_cycle = '0;
            m_ovf   = 1'b0;
        end else begin
            popped = (n > 0) && out_ready;
            if (popped) void'(exp_q.pop_front());
            if (d_w && daddr == 10'h200) begin
                if (n < FIFO_DEPTH || popped) exp_q.push_back(ddata_w);
                else                          m_ovf = 1'b1;
            end
            if (d_w && daddr == 10'h201) m_ovf = 1'b0;
            if (d_w && daddr == 10'h202) m_cycle = ddata_w;
            else                         m_cycle = m_cycle + 1;
        end
    end

    function automatic logic [DATA_W-1:0] exp_read(input logic rd, input logic [ADDR_W-1:0] a);
        int n = exp_q.size();
        if (!rd)          return '0;
        if (!a[9])        return m_ram[a[8:0]];
        if (a[8:2] != 0)  return '0;
        case (a[1:0])
            2'd0:    return DATA_W'(n);
            2'd1:    return DATA_W'(n * 256 + (m_ovf ? 4 : 0)
                                    + ((n == FIFO_DEPTH) ? 2 : 0) + ((n == 0) ? 1 : 0));
            2'd2:    return m_cycle;
            default: return '0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] exp_head();
        if (exp_q.size() == 0) return '0;
        return exp_q[0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_bus(input logic w, input logic r, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d);
        d_w     = w;
        d_r     = r;
        daddr   = a;
        ddata_w = d;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        set_bus(0, 0, '0, '0);
        tick();
        RST = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        out_ready = 1'b0;
        RST = 1'b1;
        set_bus(0, 0, '0, '0);
        tick();
        tick();
        RST = 1'b0;
        set_bus(0, 1, 10'h202, '0);
        @(negedge CLK);
        total++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            bad++;
            $display("FAIL reset_out: valid=%b data=%h want valid=0 data=0", out_valid, out_data);
        end
        total++;
        if (ddata_r !== 32'd0) begin
            bad++;
            $display("FAIL reset_cycle: got %h want 0", ddata_r);
        end
        tick();
        set_bus(0, 1, 10'h201, '0);
        @(negedge CLK);
        total++;
        if (ddata_r !== 32'h1) begin
            bad++;
            $display("FAIL reset_status: got %h want 00000001", ddata_r);
        end
        tick();
        set_bus(0, 0, '0, '0);
    endtask

    task automatic test_ram();
        logic [DATA_W-1:0] v [8];
        set_bus(1, 0, 10'h005, 32'hDEADBEEF);
        tick();
        set_bus(0, 1, 10'h005, '0);
        @(negedge CLK);
        total++;
        if (ddata_r !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL ram_rd5: got %h want deadbeef", ddata_r);
        end
        tick();
        set_bus(0, 1, 10'h205, '0);
        @(negedge CLK);
        total++;
        if (ddata_r !== 32'h0) begin
            bad++;
            $display("FAIL unmapped_rd: got %h want 0", ddata_r);
        end
        tick();
        // read and write of the same word in one cycle: old value returned
        set_bus(1, 1, 10'h005, 32'h12345678);
        @(negedge CLK);
        total++;
        if (ddata_r !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL ram_rw_same: got %h want deadbeef", ddata_r);
        end
        tick();
        set_bus(0, 1, 10'h005, '0);
        @(negedge CLK);
        total++;
        if (ddata_r !== 32'h12345678) begin
            bad++;
            $display("FAIL ram_after_rw: got %h want 12345678", ddata_r);
        end
        tick();
        set_bus(1, 0, 10'h005, 32'hDEADBEEF);
        tick();
        for (int i = 0; i < 8; i++) begin
            v[i] = $urandom;
            set_bus(1, 0, ADDR_W'(16 + i * 37), v[i]);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            set_bus(0, 1, ADDR_W'(16 + i * 37), '0);
            @(negedge CLK);
            total++;
            if (ddata_r !== v[i]) begin
                bad++;
                $display("FAIL ram_rand[%0d]: got %h want %h", i, ddata_r, v[i]);
            end
            tick();
        end
        set_bus(0, 0, '0, '0);
    endtask

    task automatic test_fifo_stream();
        logic [DATA_W-1:0] vals [5];
        logic [DATA_W-1:0] got [$];
        vals = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_bus(1, 0, 10'h200, vals[i]);
            @(negedge CLK);
            total++;
            if (i == 0 && out_valid !== 1'b0) begin
                bad++;
                $display("FAIL stream_idle: valid=%b want 0", out_valid);
            end else if (i > 0 && (out_valid !== 1'b1 || out_data !== vals[i-1])) begin
                bad++;
                $display("FAIL stream_lat[%0d]: valid=%b data=%h want 1 %h", i, out_valid, out_data, vals[i-1]);
            end
            if (out_valid && out_ready) got.push_back(out_data);
            tick();
        end
        set_bus(0, 0, '0, '0);
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (out_valid && out_ready) got.push_back(out_data);
            tick();
        end
        total++;
        if (got.size() != 5) begin
            bad++;
            $display("FAIL stream_len: got %0d words want 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                total++;
                if (got[i] !== vals[i]) begin
                    bad++;
                    $display("FAIL stream_word[%0d]: got %h want %h", i, got[i], vals[i]);
                end
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] w [9];
        logic [DATA_W-1:0] got [$];
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            w[i] = $urandom;
            set_bus(1, 0, 10'h200, w[i]);
            tick();
        end
        set_bus(0, 1, 10'h201, '0);
        @(negedge CLK);
        total++;
        if (ddata_r !== 32'h0806 || ddata_r !== exp_read(1'b1, 10'h201)) begin
            bad++;
            $display("FAIL ovf_status: got %h want 00000806", ddata_r);
        end
        tick();
        set_bus(0, 1, 10'h200, '0);
        @(negedge CLK);
        total++;
        if (ddata_r !== 32'd8) begin
            bad++;
            $display("FAIL ovf_count: got %0d want 8", ddata_r);
        end
        tick();
        set_bus(1, 0, 10'h201, $urandom);
        tick();
        set_bus(0, 1, 10'h201, '0);
        @(negedge CLK);
        total++;
        if (ddata_r !== 32'h0802) begin
            bad++;
            $display("FAIL ovf_clear: got %h want 00000802", ddata_r);
        end
        tick();
        set_bus(0, 0, '0, '0);
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (out_valid && out_ready) got.push_back(out_data);
            tick();
        end
        out_ready = 1'b0;
        total++;
        if (got.size() != 8) begin
            bad++;
            $display("FAIL ovf_drain_len: got %0d words want 8", got.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (got[i] !== w[i]) begin
                    bad++;
                    $display("FAIL ovf_drain[%0d]: got %h want %h", i, got[i], w[i]);
                end
            end
        end
    endtask

    task automatic test_full_pop();
        logic [DATA_W-1:0] w [8];
        logic [DATA_W-1:0] got [$];
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            w[i] = $urandom_range(256, 65535);
            set_bus(1, 0, 10'h200, w[i]);
            tick();
        end
        out_ready = 1'b1;
        set_bus(1, 0, 10'h200, 32'h55);
        @(negedge CLK);
        total++;
        if (out_valid !== 1'b1 || out_data !== w[0]) begin
            bad++;
            $display("FAIL fullpop_head: valid=%b data=%h want 1 %h", out_valid, out_data, w[0]);
        end
        tick();
        out_ready = 1'b0;
        set_bus(0, 1, 10'h201, '0);
        @(negedge CLK);
        total++;
        if (ddata_r !== 32'h0802) begin
            bad++;
            $display("FAIL fullpop_status: got %h want 00000802", ddata_r);
        end
        tick();
        set_bus(0, 0, '0, '0);
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge CLK);
            if (out_valid && out_ready) got.push_back(out_data);
            tick();
        end
        out_ready = 1'b0;
        total++;
        if (got.size() != 8 || got[7] !== 32'h55 || got[0] !== w[1]) begin
            bad++;
            $display("FAIL fullpop_drain: len=%0d last=%h first=%h want 8 00000055 %h",
                     got.size(), (got.size() > 0) ? got[got.size()-1] : 32'h0,
                     (got.size() > 0) ? got[0] : 32'h0, w[1]);
        end
    endtask

    task automatic test_cycle();
        out_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        set_bus(0, 1, 10'h202, '0);
        @(negedge CLK);
        total++;
        if (ddata_r !== 32'd10) begin
            bad++;
            $display("FAIL cycle_10: got %0d want 10", ddata_r);
        end
        tick();
        set_bus(1, 0, 10'h202, 32'hFFFFFFFE);
        tick();
        set_bus(0, 1, 10'h202, '0);
        @(negedge CLK);
        total++;
        if (ddata_r !== 32'hFFFFFFFE) begin
            bad++;
            $display("FAIL cycle_load: got %h want fffffffe", ddata_r);
        end
        tick();
        @(negedge CLK);
        total++;
        if (ddata_r !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL cycle_inc: got %h want ffffffff", ddata_r);
        end
        tick();
        @(negedge CLK);
        total++;
        if (ddata_r !== 32'h0) begin
            bad++;
            $display("FAIL cycle_wrap: got %h want 00000000", ddata_r);
        end
        tick();
        set_bus(0, 0, '0, '0);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_bus(1, 0, 10'h200, $urandom);
            tick();
        end
        set_bus(0, 0, '0, '0);
        @(negedge CLK);
        total++;
        if (out_valid !== 1'b1) begin
            bad++;
            $display("FAIL mid_queued: valid=%b want 1", out_valid);
        end
        tick();
        do_reset();
        set_bus(0, 1, 10'h202, '0);
        @(negedge CLK);
        total++;
        if (out_valid !== 1'b0 || out_data !== '0 || ddata_r !== 32'h0) begin
            bad++;
            $display("FAIL mid_after_rst: valid=%b data=%h cycle=%h want 0 0 0", out_valid, out_data, ddata_r);
        end
        tick();
        set_bus(0, 1, 10'h200, '0);
        @(negedge CLK);
        total++;
        if (ddata_r !== 32'h0) begin
            bad++;
            $display("FAIL mid_count: got %0d want 0", ddata_r);
        end
        tick();
        set_bus(0, 1, 10'h005, '0);
        @(negedge CLK);
        total++;
        if (ddata_r !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL mid_ram_kept: got %h want deadbeef", ddata_r);
        end
        tick();
        set_bus(0, 0, '0, '0);
    endtask

`ifdef DMEM_ERR_EN
    task automatic test_err();
        do_reset();
        @(negedge CLK);
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL err_reset: got %b want 0", err);
        end
        set_bus(1, 1, 10'h010, 32'h1);
        tick();
        set_bus(0, 0, '0, '0);
        tick();
        @(negedge CLK);
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
        tick();
        do_reset();
    endtask
`endif

    task automatic test_random();
        logic              r;
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] e;
        for (int i = 0; i < 16; i++) begin
            set_bus(1, 0, ADDR_W'(i), $urandom);
            tick();
        end
        for (int c = 0; c < 400; c++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 5)      a = ADDR_W'($urandom_range(0, 15));
            else if (sel < 9) a = ADDR_W'(10'h200 + $urandom_range(0, 3));
            else              a = ADDR_W'(10'h200 + ($urandom_range(1, 127) << 2) + $urandom_range(0, 3));
            r = ($urandom_range(0, 2) != 0);
            w = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) == 0);
            set_bus(w, r, a, (a == 10'h202 && $urandom_range(0, 1) == 1) ? 32'hFFFFFFF0 : $urandom);
            @(negedge CLK);
            e = exp_read(r, a);
            total++;
            if (ddata_r !== e) begin
                bad++;
                $display("FAIL rand_rd c=%0d addr=%h: got %h want %h", c, a, ddata_r, e);
            end
            total++;
            if (out_valid !== (exp_q.size() > 0) || out_data !== exp_head()) begin
                bad++;
                $display("FAIL rand_out c=%0d: valid=%b data=%h want %b %h",
                         c, out_valid, out_data, (exp_q.size() > 0), exp_head());
            end
            tick();
        end
        set_bus(0, 0, '0, '0);
        out_ready = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        RST       = 1'b1;
        out_ready = 1'b0;
        set_bus(0, 0, '0, '0);
        test_reset();
        test_ram();
        test_fifo_stream();
        test_overflow();
        test_full_pop();
        test_cycle();
        test_reset_mid();
`ifdef DMEM_ERR_EN
        test_err();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
